// File: rtl/q1cau_pkg.sv
// Shared definitions for the single-qubit CAU sequencer and its sibling
// sequencers.
package q1cau_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    OP    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int CYCLES_PER_PAIR = 3;

  function automatic int NPAIRS(input int nq);
    return 1 << (nq - 1);
  endfunction

  // The pair counter needs at least one bit even when only one pair exists.
  function automatic int KWIDTH(input int nq);
    return (nq > 1) ? nq - 1 : 1;
  endfunction

endpackage

// File: rtl/pair_addr_gen.sv
// Maps pair index k and target qubit t to the amplitude pair (i, j):
// i has a 0 spliced in at bit t, j is i with bit t set.
module pair_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int KW     = 3,
  parameter int QB_W   = 3
) (
  input  logic [KW-1:0]     k_i,
  input  logic [QB_W-1:0]   t_i,
  output logic [ADDR_W-1:0] i_o,
  output logic [ADDR_W-1:0] j_o
);

  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] bit_t;
  logic [ADDR_W-1:0] low_mask;

  // Bits of k below t stay put; bits at or above t move up by one.
  always_comb begin
    k_ext    = ADDR_W'(k_i);
    bit_t    = ADDR_W'(1) << t_i;
    low_mask = bit_t - ADDR_W'(1);
    i_o      = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    j_o      = i_o | bit_t;
  end

endmodule

// File: rtl/q1cau_seq.sv
// Sequencer for the dual CAU: walks every amplitude pair of the target qubit,
// issuing read, unit-operate and write-back cycles, and tracks overflow.
module q1cau_seq
  import q1cau_pkg::*;
#(
  parameter int NQ     = 4,
  parameter int ADDR_W = NQ,
  parameter int QB_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [QB_W-1:0]   target,
  input  logic              op_sum,
  input  logic              op_abs,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              cau_sel,
  output logic              cau_sum,
  output logic              cau_abs,
  output logic              cau_w_en,
  input  logic              cau_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  localparam int            KW     = KWIDTH(NQ);
  localparam logic [KW-1:0] K_LAST = KW'(NPAIRS(NQ) - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [QB_W-1:0]   target_q, target_d;
  logic              op_sum_q, op_sum_d;
  logic              op_abs_q, op_abs_d;
  logic              err_q, err_d;
  logic              overflow_q, overflow_d;

  logic              target_bad;
  logic [ADDR_W-1:0] pair_i, pair_j;

  assign target_bad = 32'(target) >= 32'(NQ);

  pair_addr_gen #(
    .ADDR_W (ADDR_W),
    .KW     (KW),
    .QB_W   (QB_W)
  ) u_pair_addr_gen (
    .k_i (k_q),
    .t_i (target_q),
    .i_o (pair_i),
    .j_o (pair_j)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      target_q   <= '0;
      op_sum_q   <= 1'b0;
      op_abs_q   <= 1'b0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      target_q   <= target_d;
      op_sum_q   <= op_sum_d;
      op_abs_q   <= op_abs_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
    end
  end

  // Stall freezes the working states only; IDLE still accepts start and
  // DONE always completes so done stays a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    target_d   = target_q;
    op_sum_d   = op_sum_q;
    op_abs_d   = op_abs_q;
    err_d      = err_q;
    overflow_d = overflow_q;
    rd_en      = 1'b0;
    cau_sum    = 1'b0;
    cau_abs    = 1'b0;
    cau_w_en   = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d   = target;
          op_sum_d   = op_sum;
          op_abs_d   = op_abs;
          overflow_d = 1'b0;
          k_d        = '0;
          err_d      = target_bad;
          state_d    = target_bad ? DONE : READ;
        end
      end
      READ: begin
        if (!stall) begin
          rd_en   = 1'b1;
          state_d = OP;
        end
      end
      OP: begin
        cau_sum = op_sum_q;
        cau_abs = op_abs_q;
        if (!stall) begin
          cau_w_en   = 1'b1;
          overflow_d = overflow_q | cau_ovf;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (!stall) begin
          wr_en = 1'b1;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == READ) || (state_q == OP) || (state_q == WRITE);
  assign cau_sel  = 1'b0;
  assign rd_addr0 = busy ? pair_i : '0;
  assign rd_addr1 = busy ? pair_j : '0;
  assign wr_addr0 = busy ? pair_i : '0;
  assign wr_addr1 = busy ? pair_j : '0;
  assign err      = err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_q1cau_seq.sv
// Self-checking bench for q1cau_seq: a per-cycle expected-trace model plus
// directed passes with hand-computed address and timing expectations.
module tb_q1cau_seq;

  localparam int NQ     = 3;
  localparam int ADDR_W = 3;
  localparam int QB_W   = 3;

  logic              clk;
  logic              rst, start, stall, op_sum, op_abs, cau_ovf;
  logic [QB_W-1:0]   target;
  logic              rd_en, cau_sel, cau_sum, cau_abs, cau_w_en, wr_en;
  logic              busy, done, err, overflow;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;

  typedef struct packed {
    logic              rd;
    logic              cw;
    logic              wr;
    logic              sum;
    logic              ab;
    logic              sel;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
  } rec_t;

  rec_t                expQ[$];
  logic                expOvf = 1'b0;
  logic                expErr = 1'b0;
  logic                opSumM = 1'b0;
  logic                opAbsM = 1'b0;
  int                  nChecks = 0;
  int                  nPass = 0;
  int                  cyc = 0;
  int                  startCyc = 0;
  int                  rdCyc[$], cwCyc[$], wrCyc[$], doneCyc[$];
  logic [2*ADDR_W-1:0] rdPairs[$], wrPairs[$];
  logic                ovfAtDone = 1'b0;

  q1cau_seq #(
    .NQ     (NQ),
    .ADDR_W (ADDR_W),
    .QB_W   (QB_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .target   (target),
    .op_sum   (op_sum),
    .op_abs   (op_abs),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .cau_sel  (cau_sel),
    .cau_sum  (cau_sum),
    .cau_abs  (cau_abs),
    .cau_w_en (cau_w_en),
    .cau_ovf  (cau_ovf),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Expected trace of a whole pass: every pair (i, i|1<<t) in ascending i,
  // each taking a read, an operate and a write cycle, then the done cycle.
  function automatic void buildPass(input int t);
    rec_t r;
    if (t < NQ) begin
      for (int i = 0; i < (1 << NQ); i++) begin
        if (((i >> t) & 1) == 0) begin
          r      = '0;
          r.busy = 1'b1;
          r.a0   = ADDR_W'(i);
          r.a1   = ADDR_W'(i | (1 << t));
          r.rd   = 1'b1;
          expQ.push_back(r);
          r.rd   = 1'b0;
          r.cw   = 1'b1;
          r.sum  = opSumM;
          r.ab   = opAbsM;
          expQ.push_back(r);
          r.cw   = 1'b0;
          r.sum  = 1'b0;
          r.ab   = 1'b0;
          r.wr   = 1'b1;
          expQ.push_back(r);
        end
      end
    end
    r      = '0;
    r.done = 1'b1;
    expQ.push_back(r);
  endfunction

  // Compare every cycle against the head of the expected trace; a stalled
  // working cycle repeats its record with the strobes suppressed.
  always @(negedge clk) begin : compare
    rec_t act, e;
    logic held;
    act      = '0;
    act.rd   = rd_en;
    act.cw   = cau_w_en;
    act.wr   = wr_en;
    act.sum  = cau_sum;
    act.ab   = cau_abs;
    act.sel  = cau_sel;
    act.busy = busy;
    act.done = done;
    act.a0   = rd_addr0;
    act.a1   = rd_addr1;
    if (rst) begin
      expQ.delete();
      expOvf = 1'b0;
      expErr = 1'b0;
      checkOutput("resetOutputs", 32'(act), 32'(0));
      checkOutput("resetFlags", 32'({overflow, err, wr_addr0, wr_addr1}), 32'(0));
    end else begin
      e    = (expQ.size() > 0) ? expQ[0] : '0;
      held = (expQ.size() > 0) && stall && e.busy;
      if (held) begin
        e.rd = 1'b0;
        e.cw = 1'b0;
        e.wr = 1'b0;
      end
      checkOutput("outputs", 32'(act), 32'(e));
      checkOutput("wrAddr", 32'({wr_addr0, wr_addr1}), 32'({e.a0, e.a1}));
      checkOutput("overflow", 32'(overflow), 32'(expOvf));
      checkOutput("err", 32'(err), 32'(expErr));
      if (rd_en) begin
        rdCyc.push_back(cyc - startCyc);
        rdPairs.push_back({rd_addr0, rd_addr1});
      end
      if (cau_w_en) cwCyc.push_back(cyc - startCyc);
      if (wr_en) begin
        wrCyc.push_back(cyc - startCyc);
        wrPairs.push_back({wr_addr0, wr_addr1});
      end
      if (done) begin
        doneCyc.push_back(cyc - startCyc);
        ovfAtDone = overflow;
      end
      if (expQ.size() > 0) begin
        if (!held) begin
          if (e.cw && cau_ovf) expOvf = 1'b1;
          void'(expQ.pop_front());
        end
      end else if (start) begin
        expOvf   = 1'b0;
        expErr   = (32'(target) >= 32'(NQ));
        opSumM   = op_sum;
        opAbsM   = op_abs;
        startCyc = cyc;
        buildPass(int'(target));
      end
    end
  end

  task automatic clearLogs();
    rdCyc.delete();
    cwCyc.delete();
    wrCyc.delete();
    doneCyc.delete();
    rdPairs.delete();
    wrPairs.delete();
  endtask

  // Drives start for cycle 0 of a pass; returns 1 ns into cycle 1.
  task automatic applyStimulus(input logic [QB_W-1:0] t, input logic s, input logic a);
    @(posedge clk);
    #1;
    target = t;
    op_sum = s;
    op_abs = a;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("passCompletes", 32'(expQ.size()), 32'(0));
  endtask

  task automatic checkTimes(input int rdT[4], input int cwT[4], input int wrT[4], input int dT);
    checkOutput("rdCount", 32'(rdCyc.size()), 32'(4));
    checkOutput("cwCount", 32'(cwCyc.size()), 32'(4));
    checkOutput("wrCount", 32'(wrCyc.size()), 32'(4));
    checkOutput("doneCount", 32'(doneCyc.size()), 32'(1));
    for (int n = 0; n < 4; n++) begin
      checkOutput("rdCycle", 32'((n < rdCyc.size()) ? rdCyc[n] : -1), 32'(rdT[n]));
      checkOutput("cwCycle", 32'((n < cwCyc.size()) ? cwCyc[n] : -1), 32'(cwT[n]));
      checkOutput("wrCycle", 32'((n < wrCyc.size()) ? wrCyc[n] : -1), 32'(wrT[n]));
    end
    checkOutput("doneCycle", 32'((doneCyc.size() > 0) ? doneCyc[0] : -1), 32'(dT));
  endtask

  task automatic checkPairs(input logic [5:0] p[4]);
    for (int n = 0; n < 4; n++) begin
      checkOutput("rdPair", 32'((n < rdPairs.size()) ? rdPairs[n] : 6'h3f), 32'(p[n]));
      checkOutput("wrPair", 32'((n < wrPairs.size()) ? wrPairs[n] : 6'h3f), 32'(p[n]));
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst     = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    op_sum  = 1'b0;
    op_abs  = 1'b0;
    cau_ovf = 1'b0;
    target  = '0;
    #1 rst  = 1'b1;
    #2;
    checkOutput("resetLiteral", 32'({rd_en, cau_w_en, wr_en, busy, done, err, overflow,
                                     rd_addr0, rd_addr1, wr_addr0, wr_addr1}), 32'(0));
    stepCycles(2);
    rst = 1'b0;

    // t=1 basic pass with sum selected
    clearLogs();
    applyStimulus(3'd1, 1'b1, 1'b0);
    waitIdle(60);
    checkTimes('{1, 4, 7, 10}, '{2, 5, 8, 11}, '{3, 6, 9, 12}, 13);
    checkPairs('{6'o02, 6'o13, 6'o46, 6'o57});

    // Overflow only in the second pair's operate cycle
    clearLogs();
    applyStimulus(3'd1, 1'b0, 1'b0);
    stepCycles(4);
    checkOutput("ovfBefore", 32'(overflow), 32'(0));
    cau_ovf = 1'b1;
    stepCycles(1);
    cau_ovf = 1'b0;
    checkOutput("ovfRise", 32'(overflow), 32'(1));
    waitIdle(60);
    checkOutput("ovfAtDone", 32'(ovfAtDone), 32'(1));

    // Next start clears overflow; t=0 pass with abs selected
    clearLogs();
    applyStimulus(3'd0, 1'b0, 1'b1);
    checkOutput("ovfCleared", 32'(overflow), 32'(0));
    waitIdle(60);
    checkTimes('{1, 4, 7, 10}, '{2, 5, 8, 11}, '{3, 6, 9, 12}, 13);
    checkPairs('{6'o01, 6'o23, 6'o45, 6'o67});

    // Five-cycle stall in the operate cycle of pair 1
    clearLogs();
    applyStimulus(3'd1, 1'b1, 1'b1);
    stepCycles(4);
    stall = 1'b1;
    stepCycles(5);
    stall = 1'b0;
    waitIdle(60);
    checkTimes('{1, 4, 12, 15}, '{2, 10, 13, 16}, '{3, 11, 14, 17}, 18);
    checkPairs('{6'o02, 6'o13, 6'o46, 6'o57});

    // Out-of-range target: error, immediate done, no traffic
    clearLogs();
    applyStimulus(3'd5, 1'b0, 1'b0);
    checkOutput("errSet", 32'(err), 32'(1));
    waitIdle(20);
    checkOutput("errDoneCount", 32'(doneCyc.size()), 32'(1));
    checkOutput("errDoneCycle", 32'((doneCyc.size() > 0) ? doneCyc[0] : -1), 32'(1));
    checkOutput("errNoTraffic", 32'(rdCyc.size() + cwCyc.size() + wrCyc.size()), 32'(0));
    checkOutput("errSticky", 32'(err), 32'(1));

    // t=2 pass with a second start mid-pass that must be ignored
    clearLogs();
    applyStimulus(3'd2, 1'b0, 1'b0);
    checkOutput("errCleared", 32'(err), 32'(0));
    stepCycles(3);
    target = 3'd0;
    start  = 1'b1;
    stepCycles(1);
    start  = 1'b0;
    waitIdle(60);
    checkTimes('{1, 4, 7, 10}, '{2, 5, 8, 11}, '{3, 6, 9, 12}, 13);
    checkPairs('{6'o04, 6'o15, 6'o26, 6'o37});

    // Asynchronous reset during the write of pair 2
    clearLogs();
    applyStimulus(3'd1, 1'b0, 1'b0);
    stepCycles(8);
    checkOutput("preResetWrite", 32'(wr_en), 32'(1));
    #1 rst = 1'b1;
    #1;
    checkOutput("asyncReset", 32'({rd_en, cau_w_en, wr_en, busy, done, err, overflow,
                                   rd_addr0, rd_addr1, wr_addr0, wr_addr1}), 32'(0));
    stepCycles(1);
    rst = 1'b0;
    stepCycles(4);
    checkOutput("noDoneAfterReset", 32'(doneCyc.size()), 32'(0));

    // Restart after reset begins from the first pair again
    clearLogs();
    applyStimulus(3'd1, 1'b0, 1'b0);
    waitIdle(60);
    checkTimes('{1, 4, 7, 10}, '{2, 5, 8, 11}, '{3, 6, 9, 12}, 13);
    checkPairs('{6'o02, 6'o13, 6'o46, 6'o57});

    stepCycles(2);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
